mux_serial_sequencer: RTL

Framing controller directly upstream of the 16:1 single-bit multiplexer. It accepts a 16-bit word on a valid/ready handshake and drives the mux data and select inputs. It steps the select through a programmable number of bit positions, one per downstream handshake, and presents the mux output as a framed serial bit stream with valid/ready/last. Together with the mux, it forms the team's parallel-to-serial path.

---
 rtl/mux_serial_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/mux_serial_sequencer.sv
// Frames a 16-bit word into a len+1 bit serial stream by stepping the select of a downstream 16:1 mux.
// First bit one cycle after accept; ser_ready low freezes select/count, and a new word is taken only on the last beat.
module mux_serial_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_nbits_m1,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mux_ip,
    output logic [3:0]  mux_s,
    input  logic        mux_op,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_last,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mux_ip_q, mux_ip_d;
    logic [3:0]  mux_s_q, mux_s_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;

    logic shifting;
    logic is_last;
    logic beat;
    logic accept;

    always_comb begin
        shifting  = (state_q == SHIFT);
        is_last   = shifting && (cnt_q == len_q);
        beat      = shifting && ser_ready;
        // Reload is allowed on the final beat so frames run back-to-back.
        in_ready  = !rst && (!shifting || (beat && is_last));
        accept    = in_valid && in_ready;

        ser_valid = shifting;
        ser_last  = is_last;
        ser_bit   = mux_op;
        busy      = shifting;
        mux_ip    = mux_ip_q;
        mux_s     = mux_s_q;

        state_d   = state_q;
        mux_ip_d  = mux_ip_q;
        mux_s_d   = mux_s_q;
        cnt_d     = cnt_q;
        len_d     = len_q;

        if (accept) begin
            state_d  = SHIFT;
            mux_ip_d = in_data;
            len_d    = in_nbits_m1;
            cnt_d    = 4'd0;
            mux_s_d  = MSB_FIRST ? in_nbits_m1 : 4'd0;
        end else if (beat) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + 4'd1;
                mux_s_d = MSB_FIRST ? (mux_s_q - 4'd1) : (mux_s_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mux_ip_q <= 16'd0;
            mux_s_q  <= 4'd0;
            cnt_q    <= 4'd0;
            len_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            mux_ip_q <= mux_ip_d;
            mux_s_q  <= mux_s_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
        end
    end

endmodule
